instruction_fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle RISC-V core. Owns the program counter, issues word fetches to instruction memory over a request/valid handshake, holds the fetched word and presents its decoded fields (Opcode, Funct3, Funct7) to the main controller. When the core retires the instruction, the unit consumes the controller's PCSrc selection plus the immediate and rs1 operands, computes the next PC and starts the next fetch.

---
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/rvalid handshake and
// holds the word for the core. Optional misaligned-target trap: IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0040_0000)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     Instr,
    output logic [6:0]      Opcode,
    output logic [2:0]      Funct3,
    output logic [6:0]      Funct7,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] PC_plus4,
    input  logic            instr_ack,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] Imm,
    input  logic [XLEN-1:0] RS1,
    output logic            fetch_error
);

    // state | meaning
    // IDLE  | one cycle after reset release, no request
    // FETCH | request outstanding at PC, waiting for imem_rvalid
    // HOLD  | instruction word valid, waiting for instr_ack
    // ERROR | misaligned target taken, stalled until reset
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic [31:0]     instr_q;
    logic            misaligned;
    logic            load_instr;
    logic            load_pc;

    always_comb begin
        target = pc + XLEN'(4);
        case (PCSrc)
            2'd0:    target = pc + XLEN'(4);
            2'd1:    target = pc + Imm;
            2'd2:    target = (RS1 + Imm) & ~XLEN'(1);
            default: target = pc;
        endcase
    end

`ifdef IFU_MISALIGN_TRAP_EN
    assign next_pc    = target;
    assign misaligned = |target[1:0];
`else
    // Without the trap, targets are silently word-aligned.
    assign next_pc    = target & ~XLEN'(3);
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        load_instr = 1'b0;
        load_pc    = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (imem_rvalid) begin
                    load_instr = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    load_pc   = 1'b1;
                    state_nxt = misaligned ? ERROR : FETCH;
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr_q <= 32'h0000_0013;
        end else begin
            state <= state_nxt;
            if (load_pc)    pc      <= next_pc;
            if (load_instr) instr_q <= imem_rdata;
        end
    end

    // Request decodes straight from state so an async reset drops it immediately.
    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
    assign Instr       = instr_q;
    assign Opcode      = instr_q[6:0];
    assign Funct3      = instr_q[14:12];
    assign Funct7      = instr_q[31:25];
    assign PC_out      = pc;
    assign PC_plus4    = pc + XLEN'(4);

`ifdef IFU_MISALIGN_TRAP_EN
    assign fetch_error = (state == ERROR);
`else
    assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: random memory/core stimulus, scoreboard of accepted
// fetches checked by an independent monitor against a next-PC reference model.
module tb_instruction_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [6:0]  Opcode;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [31:0] PC_out;
    logic [31:0] PC_plus4;
    logic        instr_ack = 1'b0;
    logic [1:0]  PCSrc = 2'd0;
    logic [31:0] Imm = 32'h0;
    logic [31:0] RS1 = 32'h0;
    logic        fetch_error;

    instruction_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .Instr(Instr),
        .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7),
        .PC_out(PC_out), .PC_plus4(PC_plus4),
        .instr_ack(instr_ack), .PCSrc(PCSrc), .Imm(Imm), .RS1(RS1),
        .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] rs1;
        int          mem_wait;
        int          ack_wait;
        logic [31:0] data;
    } op_t;

    fetch_t      exp_q[$];
    fetch_t      held = '{addr: 32'h0040_0000, data: 32'h0000_0013};
    logic [31:0] model_pc = RESET_PC;
    logic        exp_err = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk_op(input logic [1:0] src, input logic [31:0] imm,
                                  input logic [31:0] rs1, input int mw, input int aw,
                                  input logic [31:0] data);
        op_t o;
        o.src = src; o.imm = imm; o.rs1 = rs1;
        o.mem_wait = mw; o.ack_wait = aw; o.data = data;
        return o;
    endfunction

    // Next PC from the architectural rules, wrapping modulo 2^32.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input op_t o);
        logic [31:0] t;
        case (o.src)
            2'd0:    t = pc + 32'd4;
            2'd1:    t = pc + o.imm;
            2'd2:    t = (o.rs1 + o.imm) & 32'hFFFF_FFFE;
            default: t = pc;
        endcase
`ifndef IFU_MISALIGN_TRAP_EN
        t = t & 32'hFFFF_FFFC;
`endif
        return t;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("fetch_error", 32'(fetch_error), 32'(exp_err));
            check("req_valid_exclusive", 32'(imem_req & instr_valid), 32'd0);
            if (imem_req) check("imem_addr", imem_addr, model_pc);
            if (imem_req && imem_rvalid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_accept: addr %h with empty scoreboard", imem_addr);
                end else begin
                    held = exp_q.pop_front();
                    if (imem_addr !== held.addr) begin
                        bad++;
                        $display("FAIL accept_addr: got %h expected %h", imem_addr, held.addr);
                    end
                end
            end
            if (instr_valid) begin
                check("Instr", Instr, held.data);
                check("Opcode", 32'(Opcode), 32'(held.data[6:0]));
                check("Funct3", 32'(Funct3), 32'(held.data[14:12]));
                check("Funct7", 32'(Funct7), 32'(held.data[31:25]));
                check("PC_out", PC_out, held.addr);
                check("PC_plus4", PC_plus4, held.addr + 32'd4);
            end
        end
    end

    task automatic do_instr(input op_t o);
        int n = 0;
        while (!imem_req && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (!imem_req) begin
            total++; bad++;
            $display("FAIL req_timeout: imem_req %b expected 1 within 30 cycles", imem_req);
            return;
        end
        repeat (o.mem_wait) begin
            imem_rvalid = 1'b0;
            instr_ack = 1'($urandom_range(0, 1));
            PCSrc = 2'($urandom); Imm = $urandom; RS1 = $urandom;
            @(posedge clk); #1;
        end
        imem_rvalid = 1'b1;
        imem_rdata  = o.data;
        instr_ack   = 1'($urandom_range(0, 1));
        exp_q.push_back('{addr: model_pc, data: o.data});
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        instr_ack   = 1'b0;
        check("fetch_latency", 32'(instr_valid), 32'd1);
        repeat (o.ack_wait) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            PCSrc = 2'($urandom); Imm = $urandom; RS1 = $urandom;
            @(posedge clk); #1;
        end
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom;
        instr_ack = 1'b1;
        PCSrc = o.src; Imm = o.imm; RS1 = o.rs1;
        model_pc = ref_next(model_pc, o);
        @(posedge clk); #1;
        instr_ack = 1'b0;
        imem_rvalid = 1'b0;
        PCSrc = 2'($urandom); Imm = $urandom; RS1 = $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
        if (model_pc[1:0] != 2'b00) exp_err = 1'b1;
`endif
        check("ack_drops_valid", 32'(instr_valid), 32'd0);
        check("ack_to_req", 32'(imem_req), 32'(!exp_err));
    endtask

    task automatic release_and_first_req();
        rst = 1'b1;
        check("idle_after_release", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        check("no_stale_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        op_t o;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_error", 32'(fetch_error), 32'd0);
        check("rst_instr", Instr, 32'h0000_0013);
        check("rst_pc", PC_out, RESET_PC);
        release_and_first_req();

        do_instr(mk_op(2'd0, 32'h0, 32'h0, 0, 0, 32'h0000_0013));
        repeat (3) do_instr(mk_op(2'd0, 32'h0, 32'h0, 3, 1, $urandom));
        check("seq_addr_410", imem_addr, 32'h0040_0010);
        do_instr(mk_op(2'd3, $urandom & 32'hFFFF_FFFC, 32'h0, 0, 2, $urandom));
        check("refetch_410", imem_addr, 32'h0040_0010);
        do_instr(mk_op(2'd1, 32'hFFFF_FFF0, 32'h0, 1, 0, $urandom));
        check("branch_back", imem_addr, 32'h0040_0000);
        do_instr(mk_op(2'd2, 32'h0000_0004, 32'hFFFF_FFF8, 0, 0, $urandom));
        check("jalr_top", imem_addr, 32'hFFFF_FFFC);
        do_instr(mk_op(2'd0, 32'h0, 32'h0, 0, 0, $urandom));
        check("wrap_zero", imem_addr, 32'h0000_0000);
        do_instr(mk_op(2'd1, 32'h0040_0000, 32'h0, 2, 0, $urandom));

        for (int i = 0; i < 150; i++) begin
            o = mk_op(2'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 2), $urandom);
`ifdef IFU_MISALIGN_TRAP_EN
            o.imm = o.imm & 32'hFFFF_FFFC;
            o.rs1 = o.rs1 & 32'hFFFF_FFFC;
`endif
            do_instr(o);
        end

        // Reset while a response is pending in FETCH.
        check("pre_reset_fetch", 32'(imem_req), 32'd1);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #2 rst = 1'b0;
        #1;
        check("reset_drops_req", 32'(imem_req), 32'd0);
        check("reset_valid", 32'(instr_valid), 32'd0);
        check("reset_instr", Instr, 32'h0000_0013);
        check("reset_pc", PC_out, RESET_PC);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        imem_rvalid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        model_pc = RESET_PC;
        release_and_first_req();
        do_instr(mk_op(2'd0, 32'h0, 32'h0, 1, 0, $urandom));

        do_instr(mk_op(2'd2, 32'h0000_0002, 32'h0040_0101, 0, 0, $urandom));
`ifdef IFU_MISALIGN_TRAP_EN
        repeat (4) begin
            @(posedge clk); #1;
            check("error_no_req", 32'(imem_req), 32'd0);
            check("error_flag", 32'(fetch_error), 32'd1);
        end
`else
        check("aligned_jalr", imem_addr, 32'h0040_0100);
        do_instr(mk_op(2'd0, 32'h0, 32'h0, 0, 0, $urandom));
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
